// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: one outstanding word fetch, instruction held for decode until accepted.
// Latency 3 cycles/instruction with zero-wait memory (REQ, WAIT, HOLD); stalls in REQ on !imem_req_ready and in HOLD on !inst_ready.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] instruction,
   output logic [5:0]  opcode,
   output logic [5:0]  func,
   output logic [31:0] inst_pc,
   output logic [31:0] pc_plus4,
   input  logic        jump,
   input  logic        branch,
   input  logic        branch_taken,
   input  logic        jump_register,
   input  logic [31:0] jr_target,
   output logic        misaligned_jr
);

   typedef enum logic [1:0] {START, REQ, WAIT, HOLD} state_t;

   state_t      state_q;
   logic [31:0] pc_q;
   logic [31:0] instr_q;
   logic [31:0] inst_pc_q;
   logic        req_vld_q;
   logic        inst_vld_q;
   logic        mis_q;
   logic [31:0] next_pc_d;
   logic [31:0] br_off;

   assign imem_req_valid = req_vld_q;
   assign imem_addr      = pc_q;
   assign inst_valid     = inst_vld_q;
   assign instruction    = instr_q;
   assign opcode         = instr_q[31:26];
   assign func           = instr_q[5:0];
   assign inst_pc        = inst_pc_q;
   assign pc_plus4       = inst_pc_q + 32'd4;
   assign misaligned_jr  = mis_q;

   assign br_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

   // Decoder controls only matter at the HOLD accept edge, where this result is loaded.
   always_comb begin
      next_pc_d = pc_plus4;
      if (jump_register) begin
         next_pc_d = {jr_target[31:2], 2'b00};
      end else if (jump) begin
         next_pc_d = {pc_plus4[31:28], instr_q[25:0], 2'b00};
      end else if (branch && branch_taken) begin
         next_pc_d = pc_plus4 + br_off;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= START;
         pc_q       <= {RESET_PC[31:2], 2'b00};
         instr_q    <= 32'h0;
         inst_pc_q  <= 32'h0;
         req_vld_q  <= 1'b0;
         inst_vld_q <= 1'b0;
         mis_q      <= 1'b0;
      end else begin
         case (state_q)
            START: begin
               state_q   <= REQ;
               req_vld_q <= 1'b1;
            end
            REQ: begin
               if (imem_req_ready) begin
                  state_q   <= WAIT;
                  req_vld_q <= 1'b0;
               end
            end
            WAIT: begin
               if (imem_rsp_valid) begin
                  state_q    <= HOLD;
                  instr_q    <= imem_rsp_data;
                  inst_pc_q  <= pc_q;
                  inst_vld_q <= 1'b1;
               end
            end
            HOLD: begin
               if (inst_vld_q && inst_ready) begin
                  state_q    <= REQ;
                  pc_q       <= next_pc_d;
                  req_vld_q  <= 1'b1;
                  inst_vld_q <= 1'b0;
                  if (jump_register && (jr_target[1:0] != 2'b00)) begin
                     mis_q <= 1'b1;
                  end
               end
            end
            default: begin
               state_q <= START;
            end
         endcase
      end
   end

endmodule
